// File: rtl/bzseq_pkg.sv
// bzseq_pkg: state encoding, default timing constants and note byte field layout for the melody sequencer.
package bzseq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_START, S_NOTE, S_GAP} state_t;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_TICK_PER_UNIT = 2000000;
   localparam int DEF_GAP = 20000;
   localparam int CODE_W = 4;
   localparam int DUR_LSB = 4;
   localparam int PITCH_LSB = 0;
   function automatic logic [CODE_W-1:0] dur_of(input logic [7:0] n);
      return n[DUR_LSB +: CODE_W];
   endfunction
   function automatic logic [7:0] mk_note(input logic [CODE_W-1:0] d, input logic [CODE_W-1:0] p);
      return (8'(d) << DUR_LSB) | (8'(p) << PITCH_LSB);
   endfunction
endpackage

// File: rtl/bzseq_unit_tick.sv
// bzseq_unit_tick: unit prescaler; wrap pulses on every TICK_PER_UNIT-th clock after clr releases.
module bzseq_unit_tick
   import bzseq_pkg::*;
#(
   parameter int TICK_PER_UNIT = DEF_TICK_PER_UNIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic wrap
);
   localparam int W = $clog2(TICK_PER_UNIT);
   logic [W-1:0] cnt;
   assign wrap = cnt == W'(TICK_PER_UNIT - 1);
   always_ff @(posedge clk)
      if (!rst || clr || wrap) cnt <= '0;
      else cnt <= cnt + W'(1);
endmodule

// File: rtl/bz_sequencer.sv
// bz_sequencer: buffers note bytes and plays them to the buzzer with timed start pulses.
// Define BZSEQ_LOOP_EN to repeat the melody until stop instead of finishing with a done pulse.
module bz_sequencer
   import bzseq_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int TICK_PER_UNIT = DEF_TICK_PER_UNIT,
   parameter int GAP = DEF_GAP
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     clr,
   input  logic                     play,
   input  logic                     stop,
   output logic                     bz_start,
   output logic [7:0]               bz_val,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int GW = $clog2(GAP);
   state_t state;
   logic [7:0] mem [DEPTH];
   logic [IW-1:0] idx, nidx;
   logic [CODE_W-1:0] len;
   logic [GW-1:0] gcnt;
   logic wrap, wr_ok, gap_end, last;
   assign full = count == CW'(DEPTH);
   assign busy = state != S_IDLE;
   assign wr_ok = rst && state == S_IDLE && wr_en && !clr && !full;
   assign gap_end = gcnt == GW'(GAP - 1);
   assign last = CW'(idx) + CW'(1) >= count;
   assign nidx = last ? '0 : idx + IW'(1);
   bzseq_unit_tick #(.TICK_PER_UNIT(TICK_PER_UNIT)) u_tick (
      .clk(clk),
      .rst(rst),
      .clr(state != S_NOTE),
      .wrap(wrap)
   );
   always_ff @(posedge clk)
      if (wr_ok) mem[count[IW-1:0]] <= wr_data;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         count <= '0;
         idx <= '0;
         len <= '0;
         gcnt <= '0;
         bz_start <= 1'b0;
         bz_val <= '0;
         done <= 1'b0;
      end else begin
         bz_start <= 1'b0;
         done <= 1'b0;
         if (state == S_IDLE && clr) count <= '0;
         else if (wr_ok) count <= count + CW'(1);
         if (state != S_IDLE && stop) begin
            state <= S_IDLE;
            bz_val <= '0;
         end else begin
            case (state)
               S_IDLE:
                  if (play && !stop && count != '0) begin
                     state <= S_START;
                     idx <= '0;
                     bz_start <= 1'b1;
                     bz_val <= mem[0];
                  end
               S_START: begin
                  state <= S_NOTE;
                  len <= dur_of(bz_val);
               end
               // one length step per unit wrap; the final wrap ends the note
               S_NOTE:
                  if (wrap) begin
                     if (len == '0) begin
                        state <= S_GAP;
                        bz_val <= '0;
                        gcnt <= '0;
                     end else len <= len - CODE_W'(1);
                  end
               S_GAP: begin
                  gcnt <= gcnt + GW'(1);
`ifdef BZSEQ_LOOP_EN
                  if (gap_end) begin
                     state <= S_START;
                     idx <= nidx;
                     bz_start <= 1'b1;
                     bz_val <= mem[nidx];
                  end
`else
                  if (gap_end && last) begin
                     state <= S_IDLE;
                     done <= 1'b1;
                  end else if (gap_end) begin
                     state <= S_START;
                     idx <= nidx;
                     bz_start <= 1'b1;
                     bz_val <= mem[nidx];
                  end
`endif
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bz_sequencer.sv
// tb_bz_sequencer: scoreboard bench; expected start/done events are queued at play and matched as the DUT emits them.
module tb_bz_sequencer;
   import bzseq_pkg::*;
   localparam int DEPTH = 4, T = 10, G = 4;
   typedef struct {bit valid; bit is_done; logic [7:0] val; int cyc;} ev_t;
   logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, clr = 1'b0, play = 1'b0, stop = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic bz_start, busy, done, full;
   logic [7:0] bz_val;
   logic [$clog2(DEPTH):0] count;
   ev_t sb[$];
   logic [7:0] m_mem [DEPTH];
   int m_count = 0, cyc = 0, n_start = 0, n_chk = 0, n_err = 0, s0 = 0, cs = 0;
   bit m_busy = 1'b0;

   bz_sequencer #(.DEPTH(DEPTH), .TICK_PER_UNIT(T), .GAP(G)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
      .play(play), .stop(stop), .bz_start(bz_start), .bz_val(bz_val),
      .busy(busy), .done(done), .count(count), .full(full)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      ev_t e;
      if (rst && (bz_start || done)) begin
         e = '{1'b0, 1'b0, 8'h00, 0};
         if (sb.size() != 0) e = sb.pop_front();
         chk(done ? "done_kind" : "start_kind", 32'({e.valid, e.is_done}), 32'({1'b1, done}));
         chk(done ? "done_cyc" : "start_cyc", cyc, e.cyc);
         if (bz_start) begin
            chk("start_val", 32'(bz_val), 32'(e.val));
            n_start++;
         end
      end
   end

   function automatic void push_play(input int t0);
      int t = t0;
      int i;
`ifdef BZSEQ_LOOP_EN
      for (int k = 0; k < 3; k++) begin
         i = k % m_count;
`else
      for (int k = 0; k < m_count; k++) begin
         i = k;
`endif
         sb.push_back('{1'b1, 1'b0, m_mem[i], t});
         t += 1 + (int'(m_mem[i][7:4]) + 1) * T + G;
      end
`ifndef BZSEQ_LOOP_EN
      sb.push_back('{1'b1, 1'b1, 8'h00, t});
`endif
   endfunction

   task automatic bus(input bit we, input bit c, input logic [7:0] b);
      @(negedge clk);
      wr_en = we; clr = c; wr_data = b;
      if (!m_busy && c) m_count = 0;
      else if (!m_busy && we && m_count < DEPTH) begin
         m_mem[m_count] = b;
         m_count++;
      end
      @(negedge clk);
      wr_en = 1'b0; clr = 1'b0;
   endtask

   task automatic go(input bit with_stop);
      @(negedge clk);
      play = 1'b1; stop = with_stop;
      if (!with_stop && !m_busy && m_count != 0) begin
         push_play(cyc + 1);
         m_busy = 1'b1;
      end
      @(negedge clk);
      play = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int i = 0;
      while ((busy || sb.size() != 0) && i < lim) begin
         @(negedge clk);
         i++;
      end
      chk("events_left", sb.size(), 0);
      chk("busy_end", int'(busy), 0);
      m_busy = 1'b0;
   endtask

   task automatic abort_at_stop();
      stop = 1'b1; cs = cyc;
      while (sb.size() != 0 && sb[$].cyc > cs) void'(sb.pop_back());
      @(negedge clk);
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_val", 32'(bz_val), 0);
      m_busy = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_start", int'(bz_start), 0);
      chk("rst_val", 32'(bz_val), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", int'(full), 0);
      rst = 1'b1;
`ifdef BZSEQ_LOOP_EN
      bus(1, 0, 8'h03);
      bus(1, 0, 8'h12);
      s0 = n_start;
      go(0);
      for (int i = 0; i < 200 && n_start < s0 + 3; i++) @(negedge clk);
      chk("loop_starts", n_start - s0, 3);
      abort_at_stop();
      repeat (40) @(negedge clk);
      chk("loop_after_stop", n_start - s0, 3);
      chk("loop_count", 32'(count), m_count);
`else
      bus(1, 0, 8'h15);
      bus(1, 0, 8'h03);
      chk("count_two", 32'(count), m_count);
      chk("full_two", int'(full), 0);
      s0 = n_start;
      go(0);
      wait_idle(200);
      chk("starts_two", n_start - s0, 2);
      bus(0, 1, 8'h00);
      chk("count_clr", 32'(count), m_count);
      for (int i = 0; i < DEPTH + 2; i++) bus(1, 0, mk_note(4'(i % 2), 4'(i + 1)));
      chk("count_full", 32'(count), DEPTH);
      chk("full_set", int'(full), 1);
      s0 = n_start;
      go(0);
      wait_idle(400);
      chk("starts_full", n_start - s0, DEPTH);
      go(0);
      repeat (20) @(negedge clk);
      bus(1, 1, 8'hff);
      chk("count_busy_wr", 32'(count), m_count);
      wait_idle(400);
      chk("count_after", 32'(count), DEPTH);
      bus(1, 1, 8'h77);
      chk("clr_wins", 32'(count), 0);
      bus(1, 0, 8'h03);
      bus(1, 0, 8'h22);
      go(0);
      repeat (4) @(negedge clk);
      abort_at_stop();
      repeat (30) @(negedge clk);
      chk("stop_keeps_count", 32'(count), 2);
      s0 = n_start;
      go(0);
      wait_idle(200);
      chk("restart_starts", n_start - s0, 2);
      bus(0, 1, 8'h00);
      go(0);
      repeat (3) @(negedge clk);
      chk("play_empty", int'(busy), 0);
      for (int i = 0; i < 3; i++) bus(1, 0, mk_note(4'(1), 4'(i + 5)));
      go(1);
      chk("play_stop_now", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("play_stop_later", int'(busy), 0);
      go(0);
      repeat (5) @(negedge clk);
`endif
      rst = 1'b0;
      sb.delete();
      m_count = 0;
      m_busy = 1'b0;
      @(negedge clk);
      chk("mid_busy", int'(busy), 0);
      chk("mid_done", int'(done), 0);
      chk("mid_start", int'(bz_start), 0);
      chk("mid_val", 32'(bz_val), 0);
      chk("mid_count", 32'(count), 0);
      chk("mid_full", int'(full), 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("final_events", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bz_sequencer.md
# bz_sequencer

Melody sequencer that drives the buzzer controller's `start`/`val` inputs: buffers up to DEPTH note bytes, then plays them back one at a time with correctly timed start pulses. Sits between the CPU/switch logic and the buzzer controller, acting as the initiator side of the buzzer's start/val interface. Note byte format matches the buzzer: `[7:4]` is duration code (length = code+1 units), `[3:0]` is pitch code (0 = rest).

## Interface
- DEPTH, 16: note buffer entries; power of two, 2..256.
- TICK_PER_UNIT, 2000000: clocks per duration unit (0.1 s at 20 MHz); must be >= 2.
- GAP, 20000: silent clocks between notes (1 ms); must be >= 4.
- clk  in  1  system clock (20 MHz).
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- wr_en  in  1  append `wr_data` at the write pointer.
- wr_data  in  8  note byte.
- clr  in  1  empty the buffer.
- play  in  1  start playback from entry 0.
- stop  in  1  abort playback.
- bz_start  out  1  one-cycle start pulse to the buzzer.
- bz_val  out  8  note byte to the buzzer; held for the whole note.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on natural completion.
- count  out  log2(DEPTH)+1  number of stored notes.
- full  out  1  count == DEPTH.

## Operation
- Reset (rst==0 at a clk edge): state IDLE, count 0, read index 0, bz_start 0, bz_val 8'h00, busy 0, done 0, full 0.
- Buffer writes are accepted only in IDLE, when not full, and when clr is low. Each write stores the byte at index count and increments count. Writes are ignored while busy or when full, with no error flag.
- clr is honoured only in IDLE and sets count to 0. If clr and wr_en are asserted together, clr wins.
- FSM states: IDLE, START, NOTE, GAP.
  - IDLE: if play==1, stop==0 and count!=0, go to START with index 0. A play with count==0 is ignored.
  - START (1 cycle): bz_val <= buf[index], bz_start=1, load the length counter with buf[index][7:4] and the unit counter with TICK_PER_UNIT; go to NOTE.
  - NOTE: lasts exactly (code+1)*TICK_PER_UNIT cycles. The unit counter wraps each unit; the length counter decrements on each wrap. On the last cycle, set bz_val <= 0 and go to GAP.
  - GAP: lasts exactly GAP cycles. At the end, if index+1 < count, increment index and go to START. Otherwise go to IDLE and pulse done.
- stop from any non-IDLE state: go to IDLE on the next edge with bz_val <= 0. Pitch 0 silences the buzzer immediately. No done pulse.
- If stop and play are asserted together, stop wins.
- Duration is built from a unit prescaler and a 4-bit length counter; no multiplier.
- count, full, and the buffer contents survive playback and stop; only clr or reset empties them.

## Timing
- play sampled at edge N in IDLE: START during cycle N+1, with bz_start high for exactly that cycle and bz_val valid from N+1.
- Start-to-start period: 1 + (code+1)*TICK_PER_UNIT + GAP cycles.
- The buzzer detects the start edge 2 cycles late. GAP >= 4 therefore guarantees its enable has dropped before the next pulse.
- done is asserted the same cycle that busy falls.
- stop at edge M: busy=0 and bz_val=0 from M+1.
- Reset mid-note: all outputs return to reset values at the next edge.

## Configuration
- BZSEQ_LOOP_EN defined: at the end of GAP for the last note, the index wraps to 0 and goes to START. Playback repeats until stop, and done is never pulsed.
- BZSEQ_LOOP_EN undefined: playback runs once, then IDLE and a done pulse.

## Structure
- Shared package `bzseq_pkg`:
  - state encoding (IDLE/START/NOTE/GAP);
  - default TICK_PER_UNIT, GAP and DEPTH constants;
  - field positions of the duration and pitch codes.
- One sub-module, `bzseq_unit_tick`: a loadable prescaler counting TICK_PER_UNIT clocks, with clear input and one-cycle wrap output.
- The buffer is a plain register array inside `bz_sequencer`.

## Test plan
All scenarios use TICK_PER_UNIT=10 and GAP=4 unless stated otherwise.
- Write 8'h15, 8'h03, then play. Expected:
  - bz_start at play+1 with bz_val=8'h15;
  - second start 1+20+4=25 cycles later with 8'h03;
  - done 15 cycles after the second start;
  - bz_start pulses exactly 2 times.
- Write DEPTH+2 notes. Expected: full=1 and count=DEPTH; the extra writes are dropped; playback emits DEPTH starts.
- During playback, assert wr_en=1 and clr=1. Expected: count unchanged; playback completes normally.
- Assert stop in the middle of NOTE. Expected: next cycle busy=0 and bz_val=0; no done pulse; a later play restarts at entry 0.
- Assert play with count=0. Expected: busy stays 0. Assert play and stop together with count=3. Expected: busy stays 0.
- With BZSEQ_LOOP_EN and 2 notes: the 3rd start carries entry 0's byte; no done pulse. Pulse rst low for one cycle mid-note. Expected: all outputs return to reset values next cycle.
